mult_div_unit: RTL

Multiply/divide execution unit that owns and writes the HI/LO register pair for the MIPS pipeline. It sits in the E stage beside the ALU, accepts mult/multu/div/divu/mthi/mtlo from the decode controller, and models multi-cycle latency with a busy counter so the hazard unit can stall. Its hi/lo outputs feed the HI/LO read-select mux, whose output is forwarded into the M stage for mfhi/mflo.

---
 rtl/mult_div_unit_pkg.sv | 33 +++
 rtl/mult_div_unit_if.sv | 40 ++++
 rtl/md_datapath.sv | 73 +++++++
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the md_op encodings, FSM state encodings, default latencies,
// the busy-counter width and a small magnitude helper used by the datapath.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_RSV6  = 3'b110,
        MD_RSV7  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 32'd5;
    localparam int unsigned DIV_CYCLES_DEF  = 32'd10;
    localparam int unsigned CNT_W           = 32'd16;

    // Two's-complement magnitude of a 32-bit value (0x80000000 maps to itself,
    // which is the correct unsigned magnitude).
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the E-stage controller and the
// multiply/divide unit.
//   start   : qualifies md_op this cycle
//   md_op   : operation code (mult_div_unit_pkg::md_op_e encoding)
//   rs_val  : forwarded rs operand
//   rt_val  : forwarded rt operand
//   busy    : multi-cycle op in progress
//   hi, lo  : architectural HI/LO registers
// master = controller side, slave = execution unit side.
interface md_if;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start,
        output md_op,
        output rs_val,
        output rt_val,
        input  busy,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  md_op,
        input  rs_val,
        input  rt_val,
        output busy,
        output hi,
        output lo
    );

endinterface

// File: rtl/md_datapath.sv
// Combinational arithmetic for the multiply/divide unit.
//   rs_val, rt_val : operands (rs is multiplicand / dividend)
//   is_signed      : 1 for MULT/DIV, 0 for MULTU/DIVU
//   prod           : 64-bit product
//   quot, rem      : quotient (toward zero) and remainder (sign of dividend)
//   div_zero       : divisor is zero; quot/rem forced to 0
//   div_ovf        : signed 0x80000000 / 0xFFFFFFFF
module md_datapath
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        is_signed,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero,
    output logic        div_ovf
);

    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic        neg_q_s;
    logic        neg_r_s;

    // Product: the low 64 bits of a 64x64 multiply of the extended operands
    // equal the signed (or unsigned) 32x32 product.
    always_comb begin
        if (is_signed) begin
            a_ext_s = {{32{rs_val[31]}}, rs_val};
            b_ext_s = {{32{rt_val[31]}}, rt_val};
        end else begin
            a_ext_s = {32'd0, rs_val};
            b_ext_s = {32'd0, rt_val};
        end
        prod = a_ext_s * b_ext_s;
    end

    // Division on magnitudes, then sign fix-up; a zero divisor is replaced by 1
    // so the divider never sees /0, and the results are forced to 0.
    always_comb begin
        div_zero = (rt_val == 32'd0);
        div_ovf  = is_signed && (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
        if (is_signed) begin
            a_mag_s = abs32(rs_val);
            b_mag_s = abs32(rt_val);
        end else begin
            a_mag_s = rs_val;
            b_mag_s = rt_val;
        end
        b_safe_s = div_zero ? 32'd1 : b_mag_s;
        q_mag_s  = a_mag_s / b_safe_s;
        r_mag_s  = a_mag_s % b_safe_s;
        neg_q_s  = is_signed && (rs_val[31] ^ rt_val[31]);
        neg_r_s  = is_signed && rs_val[31];
        if (div_zero) begin
            quot = 32'd0;
            rem  = 32'd0;
        end else if (div_ovf) begin
            quot = 32'h8000_0000;
            rem  = 32'd0;
        end else begin
            quot = neg_q_s ? (32'd0 - q_mag_s) : q_mag_s;
            rem  = neg_r_s ? (32'd0 - r_mag_s) : r_mag_s;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide execution unit owning the HI/LO register pair.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : md_if.slave (start, md_op, rs_val, rt_val in; busy, hi, lo out)
// The result is computed at accept time into pending registers and committed
// to HI/LO when the busy counter expires; a zero divisor suppresses commit.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    md_state_e        state_r;
    md_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_hi_nxt_s;
    logic [31:0]      pend_lo_r;
    logic [31:0]      pend_lo_nxt_s;
    logic             pend_ok_r;
    logic             pend_ok_nxt_s;
    logic [31:0]      hi_r;
    logic [31:0]      hi_nxt_s;
    logic [31:0]      lo_r;
    logic [31:0]      lo_nxt_s;
    logic             busy_r;

    md_op_e           op_s;
    logic             is_signed_s;
    logic [63:0]      prod_s;
    logic [31:0]      quot_s;
    logic [31:0]      rem_s;
    logic             div_zero_s;
    logic             div_ovf_s;

    assign op_s        = md_op_e'(bus.md_op);
    assign is_signed_s = (op_s == MD_MULT) || (op_s == MD_DIV);

    md_datapath u_datapath (
        .rs_val    (bus.rs_val),
        .rt_val    (bus.rt_val),
        .is_signed (is_signed_s),
        .prod      (prod_s),
        .quot      (quot_s),
        .rem       (rem_s),
        .div_zero  (div_zero_s),
        .div_ovf   (div_ovf_s)
    );

    // Next-state, counter, pending and HI/LO update logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pend_hi_nxt_s = pend_hi_r;
        pend_lo_nxt_s = pend_lo_r;
        pend_ok_nxt_s = pend_ok_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    case (op_s)
                        MD_MULT, MD_MULTU: begin
                            state_nxt_s   = ST_MUL;
                            cnt_nxt_s     = CNT_W'(MULT_CYCLES);
                            pend_hi_nxt_s = prod_s[63:32];
                            pend_lo_nxt_s = prod_s[31:0];
                            pend_ok_nxt_s = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_nxt_s   = ST_DIV;
                            cnt_nxt_s     = CNT_W'(DIV_CYCLES);
                            pend_hi_nxt_s = div_ovf_s ? 32'd0 : rem_s;
                            pend_lo_nxt_s = div_ovf_s ? 32'h8000_0000 : quot_s;
                            pend_ok_nxt_s = ~div_zero_s;
                        end
                        MD_MTHI: hi_nxt_s = bus.rs_val;
                        MD_MTLO: lo_nxt_s = bus.rs_val;
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                // Counter at 1 means this edge is the last busy edge: commit now.
                if (cnt_r <= CNT_W'(1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    if (pend_ok_r) begin
                        hi_nxt_s = pend_hi_r;
                        lo_nxt_s = pend_lo_r;
                    end else begin
                        hi_nxt_s = hi_r;
                        lo_nxt_s = lo_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, pending and architectural register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_ok_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pend_hi_r <= pend_hi_nxt_s;
            pend_lo_r <= pend_lo_nxt_s;
            pend_ok_r <= pend_ok_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule
